// File: rtl/fft4_sequencer.sv
// fft4_sequencer: 4-point radix-2 DIT FFT sequencer driving an external butterfly; ports: clk/rst_n, in_valid/in_ready/in_data sample input, bf_a/bf_b/bf_w to butterfly, bf_out0/bf_out1 from butterfly, out_valid/out_ready/out_data/out_index results, busy
module fft4_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] bf_a,
  output logic [WIDTH-1:0] bf_b,
  output logic [WIDTH-1:0] bf_w,
  input  logic [WIDTH-1:0] bf_out0,
  input  logic [WIDTH-1:0] bf_out1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_index,
  output logic             busy
);
  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] W0 = {HALF'(1), HALF'(0)};
  localparam logic [WIDTH-1:0] W1 = {HALF'(0), {HALF{1'b1}}};
  typedef enum logic [2:0] {LOAD, S1A, S1B, S2A, S2B, OUT} state_t;
  state_t state, nxt;
  logic [1:0] n, k, ia, ib;
  logic full, compute;
  logic [WIDTH-1:0] r [4];
  always_comb begin
    nxt = state;
    ia = 2'd0;
    ib = 2'd0;
    bf_w = '0;
    case (state)
      LOAD: nxt = full ? S1A : LOAD;
      S1A: begin ia = 2'd0; ib = 2'd1; bf_w = W0; nxt = S1B; end
      S1B: begin ia = 2'd2; ib = 2'd3; bf_w = W0; nxt = S2A; end
      S2A: begin ia = 2'd0; ib = 2'd2; bf_w = W0; nxt = S2B; end
      S2B: begin ia = 2'd1; ib = 2'd3; bf_w = W1; nxt = OUT; end
      OUT: nxt = (out_ready && k == 2'd3) ? LOAD : OUT;
      default: nxt = LOAD;
    endcase
  end
  // full marks the cycle after x3 is taken: still LOAD, but no more samples accepted
  assign compute = state inside {S1A, S1B, S2A, S2B};
  assign bf_a = compute ? r[ia] : '0;
  assign bf_b = compute ? r[ib] : '0;
  assign in_ready = state == LOAD && !full;
  assign out_valid = state == OUT;
  assign out_data = out_valid ? r[k] : '0;
  assign out_index = k;
  assign busy = state != LOAD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      n <= 2'd0;
      k <= 2'd0;
      full <= 1'b0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      state <= nxt;
      if (in_valid && in_ready) begin
        r[{n[0], n[1]}] <= in_data;
        n <= n + 2'd1;
        full <= n == 2'd3;
      end else if (full) full <= 1'b0;
      if (compute) begin
        r[ia] <= bf_out0;
        r[ib] <= bf_out1;
      end
      if (out_valid && out_ready) k <= k + 2'd1;
    end
  end
endmodule

// File: tb/tb_fft4_sequencer.sv
// tb_fft4_sequencer: scoreboard bench for fft4_sequencer with a behavioural complex butterfly
module tb_fft4_sequencer;
  typedef logic [31:0] vec_t [4];
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, busy;
  logic [31:0] bf_a, bf_b, bf_w, bf_out0, bf_out1, out_data;
  logic [1:0] out_index;
  int compared = 0, mismatched = 0, cyc = 0, accept_cyc = 0;
  bit in_frame = 0, prev_ov = 0, held = 0;
  logic [31:0] held_data;
  logic [1:0] held_idx;
  logic [33:0] q [$];
  vec_t xs, es;

  fft4_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_out0(bf_out0), .bf_out1(bf_out1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference butterfly: A +/- B*W, each part wraps modulo 2^16
  logic signed [15:0] pr, pi;
  always_comb begin
    pr = $signed(bf_b[31:16]) * $signed(bf_w[31:16]) - $signed(bf_b[15:0]) * $signed(bf_w[15:0]);
    pi = $signed(bf_b[31:16]) * $signed(bf_w[15:0]) + $signed(bf_b[15:0]) * $signed(bf_w[31:16]);
    bf_out0 = {bf_a[31:16] + pr, bf_a[15:0] + pi};
    bf_out1 = {bf_a[31:16] - pr, bf_a[15:0] - pi};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov <= 0;
      held <= 0;
    end else begin
      if (held && out_valid) begin
        chk("hold_data", out_data, held_data);
        chk("hold_index", {30'd0, out_index}, {30'd0, held_idx});
      end
      if (in_frame && in_ready) chk("in_ready_low", {31'd0, in_ready}, 32'd0);
      if (out_valid && !prev_ov) chk("latency", cyc - accept_cyc, 5);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", {30'd0, out_index}, 32'hFFFFFFFF);
        else begin
          logic [33:0] e;
          e = q.pop_front();
          chk("out_data", out_data, e[31:0]);
          chk("out_index", {30'd0, out_index}, {30'd0, e[33:32]});
          if (e[33:32] == 2'd3) in_frame <= 0;
        end
      end
      prev_ov <= out_valid;
      held <= out_valid && !out_ready;
      held_data <= out_data;
      held_idx <= out_index;
    end
  end

  task automatic send(input vec_t x, input vec_t e, input int gap, input bit push, input bit hold);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) begin
        in_valid = 0;
        repeat (gap) @(posedge clk);
        #1;
      end
      in_valid = 1;
      in_data = x[i];
      begin
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1;
    end
    accept_cyc = cyc;
    in_frame = 1;
    if (push) for (int i = 0; i < 4; i++) q.push_back({2'(i), e[i]});
    in_valid = hold;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || in_frame) && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (t >= 200) chk("drain_timeout", q.size(), 0);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", {30'd0, out_index}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_bf", bf_a | bf_b | bf_w, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    xs = '{32'h00010000, 0, 0, 0};
    es = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
    send(xs, es, 0, 1, 0);
    drain();
    xs = '{0, 32'h00010000, 0, 0};
    es = '{32'h00010000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000001};
    send(xs, es, 2, 1, 0);
    drain();
    xs = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
    es = '{32'h00040000, 0, 0, 0};
    send(xs, es, 0, 1, 0);
    drain();
    xs = '{32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000};
    es = '{32'hFFFC0000, 0, 0, 0};
    send(xs, es, 0, 1, 0);
    drain();
    xs = '{0, 32'h00010000, 0, 0};
    es = '{32'h00010000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000001};
    send(xs, es, 0, 1, 0);
    begin
      int t = 0;
      do begin
        @(posedge clk);
        #1;
        t++;
      end while (!(out_valid && out_index == 2'd1) && t < 50);
      if (t >= 50) chk("bp_timeout", 0, 1);
      out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1;
    end
    drain();
    xs = '{32'h12340000, 32'h00005678, 32'h00010001, 32'h7FFF8000};
    send(xs, es, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    in_frame = 0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    xs = '{32'h00010000, 0, 0, 0};
    es = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
    send(xs, es, 0, 1, 0);
    drain();
    xs = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
    es = '{32'h00040000, 0, 0, 0};
    send(xs, es, 0, 1, 1);
    xs = '{0, 32'h00010000, 0, 0};
    es = '{32'h00010000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000001};
    send(xs, es, 0, 1, 0);
    drain();
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
